vjp_src: RTL and testbench
==========================

VJP_SRC -- requirements
Module: vjp_src

Interface
REQ-001 SHALL have clk, input, 1, system clock (50 MHz, same domain as joypad controller).
REQ-002 SHALL have rst, input, 1: reset, synchronous, active-high; clock clk.
REQ-003 SHALL have jp_latch, input, 1: latch strobe from joypad controller, registered in clk domain.
REQ-004 SHALL have jp_clk, input, 1: shift clock from joypad controller, registered in clk domain.
REQ-005 SHALL have phys_data1 / phys_data2, input, 1 each: serial data from physical pads, active-low.
REQ-006 SHALL have host_wr, input, 1: host register write strobe, one write per asserted cycle.
REQ-007 SHALL have host_addr, input, 2: register select.
REQ-008 SHALL have host_din, input, 8: register write data.
REQ-009 SHALL have jp_data1 / jp_data2, output, 1 each: serial data to joypad controller, active-low.
REQ-010 SHALL have turbo_phase, output, 1: current turbo phase.

Function
REQ-011 Button byte order SHALL be bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right; 1 = pressed.
REQ-012 Host registers SHALL be: addr 0 pad1 buttons, addr 1 pad2 buttons, addr 2 turbo mask {[3] pad2 B, [2] pad2 A, [1] pad1 B, [0] pad1 A}, addr 3 mode {[7:4] turbo period, [3:2] pad2 src, [1:0] pad1 src}.
REQ-013 Register writes SHALL take effect the cycle after host_wr; mask bits [7:4] ignored.
REQ-014 Src encoding SHALL be 00 physical, 01 host, 10 merge, 11 treated as 00.
REQ-015 Per pad, an 8-bit shift register SHALL hold active-high host button state.
REQ-016 Load value SHALL be host buttons, with turbo-masked A/B bits forced 0 while turbo_phase = 1.
REQ-017 While jp_latch = 1, shift register SHALL reload load value every cycle (level-sensitive).
REQ-018 Rising edge of jp_clk (prev sample 0, current 1) with jp_latch = 0 SHALL shift right one bit, shifting 0 into bit7; detection latency one cycle.
REQ-019 jp_latch = 1 SHALL take priority over a simultaneous jp_clk edge.
REQ-020 After 8+ shifts, host serial bit SHALL read released (output 1) until next latch.
REQ-021 Host serial bit SHALL be registered ~shift[0]; valid 1 cycle after load/shift, well inside 16-cycle controller sample margin.
REQ-022 jp_dataN SHALL be: src 00 -> phys_dataN combinationally; src 01 -> host serial bit; src 10 -> host serial bit AND phys_dataN (press on either reports pressed).
REQ-023 Turbo counter (4 bits) SHALL increment on each jp_latch rising edge; on reaching period-1 it wraps to 0 and toggles turbo_phase.
REQ-024 Period 0 SHALL disable turbo: counter held 0, turbo_phase forced 0; period 1 toggles every latch.
REQ-025 Writing mode SHALL clear turbo counter but not turbo_phase.
REQ-026 Host write coincident with a load cycle SHALL load the old value; new value seen next load cycle.
REQ-027 Host writes mid-scan SHALL NOT disturb the shift register contents.
REQ-028 Src change mid-scan SHALL switch jp_dataN output immediately (no resync).

Reset
REQ-029 On rst: all button, mask and mode registers 0; shift registers 0; turbo counter 0; turbo_phase 0; edge-detect prev samples 0.
REQ-030 After rst, jp_data1/2 SHALL equal phys_data1/2 (src 00); host serial bits = 1.
REQ-031 rst asserted mid-scan SHALL abort scan; next scan starts only on new jp_latch.

Verification
REQ-032 Mode 0x05, pad1 0x81, latch pulse then 7 clk pulses -> jp_data1 sequence 0,1,1,1,1,1,1,0 then 1 on 9th clk.
REQ-033 Mode 0x00, phys_data1 toggled arbitrarily -> jp_data1 tracks phys_data1 same cycle, host regs ignored.
REQ-034 Mode 0x02, pad1 0x01, phys_data1 = 0 on bit3 only -> reads pressed on A and Start.
REQ-035 Mode 0x21 (period 2), pad1 0x03, mask 0x01, 6 latch pulses -> A reads 1,1,0,0,1,1 pattern (pressed, pressed, released, released, ...); B always pressed.
REQ-036 Write pad1 0xFF on same cycle latch high then mid-scan write 0x00 -> current scan reports old value then all pressed next scan... first loads old; following latch cycle loads 0xFF; 0x00 seen on next scan.
REQ-037 rst asserted after 3 shifts -> jp_data outputs return to phys pass-through, turbo_phase 0.

Source files
------------

// File: rtl/vjp_src_if.sv
// Host register bus for vjp_src.
//   host_wr   : write strobe, one register write per asserted cycle
//   host_addr : register select (0 pad1, 1 pad2, 2 turbo mask, 3 mode)
//   host_din  : write data
// The master modport belongs to the host, and the slave modport to vjp_src.
interface vjp_src_if;
  logic       host_wr;
  logic [1:0] host_addr;
  logic [7:0] host_din;

  modport master (output host_wr, output host_addr, output host_din);
  modport slave  (input  host_wr, input  host_addr, input  host_din);
endinterface

// File: rtl/vjp_src.sv
// vjp_src -- virtual joypad source.
// Stands in for up to two serial joypads. For each pad, the source is the
// physical pad, a host-programmed button byte, or a merge of the two. Turbo
// can auto-release the A/B buttons on alternating latch periods.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   jp_latch, jp_clk    : latch strobe / shift clock from the joypad controller
//   phys_data1/2        : active-low serial data from the physical pads
//   host                : host register bus (vjp_src_if.slave)
//   jp_data1/2          : active-low serial data to the joypad controller
//   turbo_phase         : current turbo phase (1 = turbo buttons released)
module vjp_src (
  input  logic          clk,
  input  logic          rst,
  input  logic          jp_latch,
  input  logic          jp_clk,
  input  logic          phys_data1,
  input  logic          phys_data2,
  vjp_src_if.slave      host,
  output logic          jp_data1,
  output logic          jp_data2,
  output logic          turbo_phase
);

  logic [7:0] r_pad1;
  logic [7:0] r_pad2;
  logic [3:0] r_mask;
  logic [7:0] r_mode;
  logic [7:0] r_shift1;
  logic [7:0] r_shift2;
  logic       r_ser1;
  logic       r_ser2;
  logic [3:0] r_cnt;
  logic       r_phase;
  logic       r_latch_prev;
  logic       r_jpclk_prev;

  logic [3:0] w_period;
  logic       w_latch_rise;
  logic       w_clk_rise;
  logic       w_mode_wr;
  logic [7:0] w_load1;
  logic [7:0] w_load2;

  // Host buttons with the turbo-masked A/B bits released during turbo phase 1.
  // tmask is {B, A} for the pad.
  function automatic logic [7:0] load_value(input logic [7:0] btn,
                                            input logic [1:0] tmask,
                                            input logic       phase);
    logic [7:0] v;
    v = btn;
    if (phase) begin
      v[0] = btn[0] & ~tmask[0];
      v[1] = btn[1] & ~tmask[1];
    end
    return v;
  endfunction

  // Output source select. Both inputs are active-low, so AND reports a press
  // from either source. Code 11 behaves like physical pass-through.
  function automatic logic pick_out(input logic [1:0] src,
                                    input logic       ser,
                                    input logic       phys);
    logic o;
    case (src)
      2'b01:   o = ser;
      2'b10:   o = ser & phys;
      default: o = phys;
    endcase
    return o;
  endfunction

  assign w_period     = r_mode[7:4];
  assign w_latch_rise = jp_latch & ~r_latch_prev;
  assign w_clk_rise   = jp_clk & ~r_jpclk_prev;
  assign w_mode_wr    = host.host_wr && (host.host_addr == 2'd3);
  assign w_load1      = load_value(r_pad1, r_mask[1:0], r_phase);
  assign w_load2      = load_value(r_pad2, r_mask[3:2], r_phase);

  // Host register file. A write lands at this edge, so a load on the same
  // cycle still sees the previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pad1 <= 8'h00;
      r_pad2 <= 8'h00;
      r_mask <= 4'h0;
      r_mode <= 8'h00;
    end else if (host.host_wr) begin
      case (host.host_addr)
        2'd0:    r_pad1 <= host.host_din;
        2'd1:    r_pad2 <= host.host_din;
        2'd2:    r_mask <= host.host_din[3:0];
        default: r_mode <= host.host_din;
      endcase
    end
  end

  // Edge-detect history for the controller strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latch_prev <= 1'b0;
      r_jpclk_prev <= 1'b0;
    end else begin
      r_latch_prev <= jp_latch;
      r_jpclk_prev <= jp_clk;
    end
  end

  // Turbo counter. Period 0 parks everything. A mode write restarts the count
  // but keeps the phase, which avoids glitching a turbo button mid-use.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_phase <= 1'b0;
    end else if (w_period == 4'd0) begin
      r_cnt   <= 4'd0;
      r_phase <= 1'b0;
    end else if (w_mode_wr) begin
      r_cnt   <= 4'd0;
    end else if (w_latch_rise) begin
      if (r_cnt >= w_period - 4'd1) begin
        r_cnt   <= 4'd0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt   <= r_cnt + 4'd1;
      end
    end
  end

  // Shift registers. A latch reloads on every cycle it is high, and takes
  // priority over a shift-clock edge. Zeros shift in from the top, so a pad
  // reads released after eight shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift1 <= 8'h00;
      r_shift2 <= 8'h00;
    end else if (jp_latch) begin
      r_shift1 <= w_load1;
      r_shift2 <= w_load2;
    end else if (w_clk_rise) begin
      r_shift1 <= {1'b0, r_shift1[7:1]};
      r_shift2 <= {1'b0, r_shift2[7:1]};
    end
  end

  // Registered active-low serial bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ser1 <= 1'b1;
      r_ser2 <= 1'b1;
    end else begin
      r_ser1 <= ~r_shift1[0];
      r_ser2 <= ~r_shift2[0];
    end
  end

  // The source mux is combinational, so a source change takes effect at once.
  always_comb begin
    jp_data1    = pick_out(r_mode[1:0], r_ser1, phys_data1);
    jp_data2    = pick_out(r_mode[3:2], r_ser2, phys_data2);
    turbo_phase = r_phase;
  end

endmodule

// File: tb/tb_vjp_src.sv
module tb_vjp_src;

  logic clk = 1'b0;
  logic rst;
  logic jp_latch;
  logic jp_clk;
  logic phys_data1;
  logic phys_data2;
  logic jp_data1;
  logic jp_data2;
  logic turbo_phase;

  vjp_src_if hif ();

  vjp_src dut (
    .clk         (clk),
    .rst         (rst),
    .jp_latch    (jp_latch),
    .jp_clk      (jp_clk),
    .phys_data1  (phys_data1),
    .phys_data2  (phys_data2),
    .host        (hif),
    .jp_data1    (jp_data1),
    .jp_data2    (jp_data2),
    .turbo_phase (turbo_phase)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] mode;
    logic       p1;
    logic       p2;
    logic       e1;
    logic       e2;
  } pt_vec_t;

  pt_vec_t pt [8];
  logic    seq1 [10];
  logic    seq2 [10];
  logic    mrg  [8];
  logic    trb  [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    hif.host_wr   = 1'b1;
    hif.host_addr = addr;
    hif.host_din  = data;
    tick();
    hif.host_wr   = 1'b0;
  endtask

  task automatic latch_pulse();
    jp_latch = 1'b1;
    tick();
    jp_latch = 1'b0;
    tick();
    tick();
  endtask

  task automatic clk_pulse();
    jp_clk = 1'b1;
    tick();
    jp_clk = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    // Pass-through vectors: src 00, src 11 and merge with an idle host bit
    // all follow the physical pad in the same cycle.
    pt[0] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    pt[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    pt[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    pt[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    pt[4] = '{8'h0F, 1'b0, 1'b1, 1'b0, 1'b1};
    pt[5] = '{8'h0F, 1'b1, 1'b0, 1'b1, 1'b0};
    pt[6] = '{8'h0A, 1'b0, 1'b1, 1'b0, 1'b1};
    pt[7] = '{8'h0A, 1'b1, 1'b0, 1'b1, 1'b0};
    // pad1 0x81 and pad2 0x42: after the latch, then after each of 9 shifts.
    seq1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    seq2 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    // Merge: host A pressed, physical pad pressed on bit 3 only.
    mrg  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    // Turbo period 2, A masked: pressed, pressed, released, released, ...
    trb  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; jp_latch = 1'b0; jp_clk = 1'b0;
    phys_data1 = 1'b1; phys_data2 = 1'b1;
    hif.host_wr = 1'b0; hif.host_addr = 2'd0; hif.host_din = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_phase", turbo_phase, 1'b0);
    phys_data1 = 1'b0; phys_data2 = 1'b1; #1;
    check("rst_pass1", jp_data1, 1'b0);
    check("rst_pass2", jp_data2, 1'b1);
    wr(2'd3, 8'h05);
    tick();
    check("rst_ser1", jp_data1, 1'b1);
    check("rst_ser2", jp_data2, 1'b1);

    // Table-driven pass-through
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      wr(2'd3, pt[i].mode);
      tick();
      phys_data1 = pt[i].p1;
      phys_data2 = pt[i].p2;
      #1;
      check($sformatf("pass1_%0d", i), jp_data1, pt[i].e1);
      check($sformatf("pass2_%0d", i), jp_data2, pt[i].e2);
    end
    phys_data1 = 1'b1; phys_data2 = 1'b1;

    // Host scan on both pads
    wr(2'd3, 8'h05);
    wr(2'd0, 8'h81);
    wr(2'd1, 8'h42);
    latch_pulse();
    check("scan1_0", jp_data1, seq1[0]);
    check("scan2_0", jp_data2, seq2[0]);
    for (int k = 1; k < 10; k++) begin
      clk_pulse();
      check($sformatf("scan1_%0d", k), jp_data1, seq1[k]);
      check($sformatf("scan2_%0d", k), jp_data2, seq2[k]);
    end
    check("period0_phase", turbo_phase, 1'b0);

    // Merge mode
    wr(2'd3, 8'h02);
    wr(2'd0, 8'h01);
    latch_pulse();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) clk_pulse();
      phys_data1 = (k == 3) ? 1'b0 : 1'b1;
      #1;
      check($sformatf("merge_%0d", k), jp_data1, mrg[k]);
    end
    phys_data1 = 1'b1;

    // A write coincident with a one-cycle latch loads the old value, and a
    // mid-scan write leaves the scan alone.
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h80);
    hif.host_wr = 1'b1; hif.host_addr = 2'd0; hif.host_din = 8'hFF;
    jp_latch = 1'b1;
    tick();
    hif.host_wr = 1'b0; jp_latch = 1'b0;
    tick(); tick();
    check("wrlatch_old_b0", jp_data1, 1'b1);
    clk_pulse();
    check("wrlatch_old_b1", jp_data1, 1'b1);
    wr(2'd0, 8'h00);
    repeat (6) clk_pulse();
    check("midscan_b7", jp_data1, 1'b0);
    // With a two-cycle latch, the second cycle picks up the new value.
    hif.host_wr = 1'b1; hif.host_addr = 2'd0; hif.host_din = 8'hFF;
    jp_latch = 1'b1;
    tick();
    hif.host_wr = 1'b0;
    tick();
    jp_latch = 1'b0;
    tick(); tick();
    check("latch2_new_b0", jp_data1, 1'b0);
    clk_pulse();
    check("latch2_new_b1", jp_data1, 1'b0);
    wr(2'd0, 8'h00);
    latch_pulse();
    check("next_scan_00", jp_data1, 1'b1);

    // Turbo period 1 toggles on every latch
    wr(2'd3, 8'h10);
    latch_pulse();
    check("p1_phase_a", turbo_phase, 1'b1);
    latch_pulse();
    check("p1_phase_b", turbo_phase, 1'b0);

    // Turbo period 2 on pad1 A
    wr(2'd3, 8'h21);
    wr(2'd0, 8'h03);
    wr(2'd2, 8'h01);
    for (int n = 0; n < 6; n++) begin
      latch_pulse();
      check($sformatf("turbo_A_%0d", n), jp_data1, trb[n]);
      clk_pulse();
      check($sformatf("turbo_B_%0d", n), jp_data1, 1'b0);
    end
    check("turbo_phase_end", turbo_phase, 1'b1);

    // A mode write keeps the phase. Reset mid-scan then aborts everything.
    wr(2'd3, 8'h25);
    tick();
    check("modewr_keeps_phase", turbo_phase, 1'b1);
    wr(2'd0, 8'h81);
    latch_pulse();
    repeat (3) clk_pulse();
    phys_data1 = 1'b0; phys_data2 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_pass1_0", jp_data1, 1'b0);
    check("rstmid_pass2_0", jp_data2, 1'b0);
    check("rstmid_phase", turbo_phase, 1'b0);
    phys_data1 = 1'b1; #1;
    check("rstmid_pass1_1", jp_data1, 1'b1);
    phys_data2 = 1'b1;
    wr(2'd0, 8'h81);
    wr(2'd3, 8'h05);
    clk_pulse();
    check("rst_no_scan", jp_data1, 1'b1);
    latch_pulse();
    check("rst_new_latch", jp_data1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
